// File: rtl/fir_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the time-multiplexed
// stereo FIR. Coefficients are symmetric, so only half of them are stored.
package fir_pkg;

  localparam int ARRAY_WIDTH = 20;
  localparam int COEFF_WIDTH = 8;
  localparam int NUM_TAPS    = 8;
  localparam int ACC_WIDTH   = 24;
  localparam int TAP_IDX_W   = $clog2(NUM_TAPS);

  localparam logic signed [COEFF_WIDTH-1:0] COEFF1 = 8'shF4;
  localparam logic signed [COEFF_WIDTH-1:0] COEFF2 = 8'shFC;
  localparam logic signed [COEFF_WIDTH-1:0] COEFF3 = 8'sh18;
  localparam logic signed [COEFF_WIDTH-1:0] COEFF4 = 8'sh33;

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = 24'sh07FFFF;
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = 24'shF80000;

  typedef enum logic [1:0] {IDLE, LOAD, MAC, SAT} state_e;

  // Tap index 0..7 maps to taps 1..8; the second half mirrors the first.
  function automatic logic signed [COEFF_WIDTH-1:0] tap_coeff(input logic [TAP_IDX_W-1:0] idx);
    case (idx)
      3'd0, 3'd7: tap_coeff = COEFF1;
      3'd1, 3'd6: tap_coeff = COEFF2;
      3'd2, 3'd5: tap_coeff = COEFF3;
      default:    tap_coeff = COEFF4;
    endcase
  endfunction

  function automatic logic signed [ARRAY_WIDTH-1:0] sat_acc(input logic signed [ACC_WIDTH-1:0] acc);
    if (acc > SAT_HI)
      sat_acc = {1'b0, {(ARRAY_WIDTH-1){1'b1}}};
    else if (acc < SAT_LO)
      sat_acc = {1'b1, {(ARRAY_WIDTH-1){1'b0}}};
    else
      sat_acc = acc[ARRAY_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Shared signed 8x8 multiply-accumulate; the accumulator is read back through
// a saturating narrowing to the sample width.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          en,
  input  logic signed [COEFF_WIDTH-1:0] smp,
  input  logic signed [COEFF_WIDTH-1:0] coef,
  output logic signed [ARRAY_WIDTH-1:0] sat_out
);

  logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic signed [2*COEFF_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]     prod_ext;

  // The product carries the top 8 sample bits, so it is realigned by 4 into the 20-bit frame.
  always_comb begin
    prod     = smp * coef;
    prod_ext = ACC_WIDTH'(prod);
    acc_d    = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = acc_q + (prod_ext <<< 4);
  end

  always_ff @(posedge clock) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign sat_out = sat_acc(acc_q);

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed 8-tap stereo FIR controller: lrck edges queue per-channel
// requests that are serviced one at a time through a single shared MAC.
module fir_mac_scheduler
  import fir_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   lrck,
  input  logic [ARRAY_WIDTH-1:0] l_codec_to_fpga,
  input  logic [ARRAY_WIDTH-1:0] r_codec_to_fpga,
  output logic [ARRAY_WIDTH-1:0] l_fpga_to_codec,
  output logic [ARRAY_WIDTH-1:0] r_fpga_to_codec,
  output logic                   l_valid,
  output logic                   r_valid,
  output logic                   busy,
  output logic                   overrun
);

  state_e                        state_q, state_d;
  logic                          sel_q, sel_d;
  logic [TAP_IDX_W-1:0]          idx_q, idx_d;
  logic [2:0]                    sync_q, sync_d;
  logic                          pend_r_q, pend_r_d, pend_l_q, pend_l_d;
  logic [ARRAY_WIDTH-1:0]        cap_r_q, cap_r_d, cap_l_q, cap_l_d;
  logic signed [ARRAY_WIDTH-1:0] dl_r_q [NUM_TAPS];
  logic signed [ARRAY_WIDTH-1:0] dl_r_d [NUM_TAPS];
  logic signed [ARRAY_WIDTH-1:0] dl_l_q [NUM_TAPS];
  logic signed [ARRAY_WIDTH-1:0] dl_l_d [NUM_TAPS];
  logic [ARRAY_WIDTH-1:0]        r_out_q, r_out_d, l_out_q, l_out_d;
  logic                          r_vld_q, r_vld_d, l_vld_q, l_vld_d;
  logic                          ovr_q, ovr_d;
  logic                          rise, fall, blk_r, blk_l, take_r, take_l, req_r, req_l;
  logic                          mac_clr, mac_en, do_load, do_sat;
  logic signed [COEFF_WIDTH-1:0] tap_hi, coef_sel;
  logic signed [ARRAY_WIDTH-1:0] mac_sat;

  // A channel that is pending or currently in service cannot accept another request.
  always_comb begin
    sync_d = {sync_q[1:0], lrck};
    rise   = sync_q[1] & ~sync_q[2];
    fall   = ~sync_q[1] & sync_q[2];
    blk_r  = pend_r_q | ((state_q != IDLE) & sel_q);
    blk_l  = pend_l_q | ((state_q != IDLE) & ~sel_q);
    take_r = rise & ~blk_r;
    take_l = fall & ~blk_l;
    req_r  = pend_r_q | take_r;
    req_l  = pend_l_q | take_l;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (req_r) begin
          state_d = LOAD;
          sel_d   = 1'b1;
        end else if (req_l) begin
          state_d = LOAD;
          sel_d   = 1'b0;
        end
      end
      LOAD: begin
        state_d = MAC;
        idx_d   = '0;
      end
      MAC: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == TAP_IDX_W'(NUM_TAPS-1)) state_d = SAT;
      end
      SAT: begin
        if (sel_q ? req_l : req_r) begin
          state_d = LOAD;
          sel_d   = ~sel_q;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    do_load  = (state_q == LOAD);
    do_sat   = (state_q == SAT);
    mac_clr  = do_load;
    mac_en   = (state_q == MAC);
    tap_hi   = sel_q ? dl_r_q[idx_q][ARRAY_WIDTH-1 -: COEFF_WIDTH]
                     : dl_l_q[idx_q][ARRAY_WIDTH-1 -: COEFF_WIDTH];
    coef_sel = tap_coeff(idx_q);
  end

  always_comb begin
    pend_r_d = pend_r_q;
    pend_l_d = pend_l_q;
    if (do_load) begin
      if (sel_q) pend_r_d = 1'b0;
      else       pend_l_d = 1'b0;
    end
    if (take_r) pend_r_d = 1'b1;
    if (take_l) pend_l_d = 1'b1;
    cap_r_d = take_r ? r_codec_to_fpga : cap_r_q;
    cap_l_d = take_l ? l_codec_to_fpga : cap_l_q;
    ovr_d   = ovr_q | (rise & blk_r) | (fall & blk_l);
    dl_r_d  = dl_r_q;
    dl_l_d  = dl_l_q;
    if (do_load) begin
      for (int k = NUM_TAPS-1; k > 0; k--) begin
        if (sel_q) dl_r_d[k] = dl_r_q[k-1];
        else       dl_l_d[k] = dl_l_q[k-1];
      end
      if (sel_q) dl_r_d[0] = cap_r_q;
      else       dl_l_d[0] = cap_l_q;
    end
    r_vld_d = do_sat & sel_q;
    l_vld_d = do_sat & ~sel_q;
    r_out_d = r_vld_d ? mac_sat : r_out_q;
    l_out_d = l_vld_d ? mac_sat : l_out_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      idx_q    <= '0;
      sync_q   <= '0;
      pend_r_q <= 1'b0;
      pend_l_q <= 1'b0;
      ovr_q    <= 1'b0;
      dl_r_q   <= '{default: '0};
      dl_l_q   <= '{default: '0};
      r_out_q  <= '0;
      l_out_q  <= '0;
      r_vld_q  <= 1'b0;
      l_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      idx_q    <= idx_d;
      sync_q   <= sync_d;
      pend_r_q <= pend_r_d;
      pend_l_q <= pend_l_d;
      ovr_q    <= ovr_d;
      dl_r_q   <= dl_r_d;
      dl_l_q   <= dl_l_d;
      r_out_q  <= r_out_d;
      l_out_q  <= l_out_d;
      r_vld_q  <= r_vld_d;
      l_vld_q  <= l_vld_d;
    end
  end

  always_ff @(posedge clock) begin
    cap_r_q <= cap_r_d;
    cap_l_q <= cap_l_d;
  end

  fir_mac_unit u_mac (
    .clock   (clock),
    .reset   (reset),
    .clr     (mac_clr),
    .en      (mac_en),
    .smp     (tap_hi),
    .coef    (coef_sel),
    .sat_out (mac_sat)
  );

  assign l_fpga_to_codec = l_out_q;
  assign r_fpga_to_codec = r_out_q;
  assign l_valid         = l_vld_q;
  assign r_valid         = r_vld_q;
  assign busy            = (state_q != IDLE);
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: impulse, DC, queued channels, overrun
// and reset in the middle of a MAC schedule, against hand-computed outputs.
module tb_fir_mac_scheduler;

  logic        clock;
  logic        reset;
  logic        lrck;
  logic [19:0] l_in, r_in;
  logic [19:0] l_out, r_out;
  logic        l_valid, r_valid, busy, overrun;

  int n_vec = 0;
  int n_err = 0;
  int r_pulses = 0;
  int l_pulses = 0;

  fir_mac_scheduler dut (
    .clock           (clock),
    .reset           (reset),
    .lrck            (lrck),
    .l_codec_to_fpga (l_in),
    .r_codec_to_fpga (r_in),
    .l_fpga_to_codec (l_out),
    .r_fpga_to_codec (r_out),
    .l_valid         (l_valid),
    .r_valid         (r_valid),
    .busy            (busy),
    .overrun         (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (r_valid) r_pulses++;
    if (l_valid) l_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // One lrck edge: the valid must follow the 13th posedge after the pin change
  // (two synchronizer clocks, the detect clock, then ten schedule clocks).
  task automatic step(input bit right, input logic [19:0] smp, input logic [19:0] exp, input string tag);
    int  c;
    bit  seen;
    @(negedge clock);
    lrck = right;
    if (right) r_in = smp;
    else       l_in = smp;
    c    = 0;
    seen = 0;
    while (!seen && c < 30) begin
      @(posedge clock);
      #1;
      c++;
      if (c == 6) chk({tag, "_busy"}, 32'(busy), 32'd1);
      seen = right ? r_valid : l_valid;
    end
    chk({tag, "_lat"}, 32'(c), 32'd13);
    chk({tag, "_val"}, 32'(right ? r_out : l_out), 32'(exp));
    repeat (4) @(posedge clock);
  endtask

  logic [19:0] imp_exp [9] = '{20'hFA0C0, 20'hFE040, 20'h0BE80, 20'h194D0, 20'h194D0,
                               20'h0BE80, 20'hFE040, 20'hFA0C0, 20'h00000};
  logic [19:0] dc_exp  [9] = '{20'h06000, 20'h08000, 20'hFC000, 20'hE2800, 20'hC9000,
                               20'hBD000, 20'hBF000, 20'hC5000, 20'hC5000};

  initial begin
    int c;
    int rp0, lp0, t_r, t_l;
    reset = 1'b1;
    lrck  = 1'b0;
    l_in  = '0;
    r_in  = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Reset then idle
    chk("rst_l_out", 32'(l_out), 32'd0);
    chk("rst_r_out", 32'(r_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    repeat (20) @(posedge clock);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pulses", 32'(r_pulses + l_pulses), 32'd0);

    // Right impulse, left channel stays silent
    for (int i = 0; i < 9; i++) begin
      step(1'b1, (i == 0) ? 20'h7FFFF : 20'h0, imp_exp[i], "imp_r");
      step(1'b0, 20'h0, 20'h0, "imp_l");
    end

    // DC at full negative scale on both channels
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 20'h80000, dc_exp[i], "dc_r");
      step(1'b0, 20'h80000, dc_exp[i], "dc_l");
    end

    // Left request queued behind right: valids 10 clocks apart
    @(negedge clock);
    lrck = 1'b1;
    r_in = 20'h0;
    t_r  = 0;
    t_l  = 0;
    c    = 0;
    while (t_l == 0 && c < 40) begin
      if (c == 3) begin
        @(negedge clock);
        lrck = 1'b0;
        l_in = 20'h0;
      end
      @(posedge clock);
      #1;
      c++;
      if (r_valid && t_r == 0) t_r = c;
      if (l_valid && t_l == 0) t_l = c;
    end
    chk("pair_r_lat", 32'(t_r), 32'd13);
    chk("pair_l_lat", 32'(t_l), 32'd23);
    chk("pair_r_val", 32'(r_out), 32'hBF000);
    chk("pair_l_val", 32'(l_out), 32'hBF000);
    chk("pair_overrun", 32'(overrun), 32'd0);
    repeat (6) @(posedge clock);

    // Second rising edge while right is still in service is dropped
    rp0 = r_pulses;
    lp0 = l_pulses;
    @(negedge clock);
    lrck = 1'b1;
    r_in = 20'h0;
    repeat (3) @(negedge clock);
    lrck = 1'b0;
    l_in = 20'h0;
    repeat (3) @(negedge clock);
    lrck = 1'b1;
    r_in = 20'h12345;
    repeat (40) @(posedge clock);
    #1;
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_r_pulses", 32'(r_pulses - rp0), 32'd1);
    chk("ovr_l_pulses", 32'(l_pulses - lp0), 32'd1);
    chk("ovr_r_val", 32'(r_out), 32'hBD000);
    chk("ovr_l_val", 32'(l_out), 32'hBD000);
    chk("ovr_idle", 32'(busy), 32'd0);

    // Reset during the 4th MAC clock of a left schedule
    lp0 = l_pulses;
    rp0 = r_pulses;
    @(negedge clock);
    lrck = 1'b0;
    l_in = 20'h7FFFF;
    repeat (7) @(posedge clock);
    @(negedge clock);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    chk("mid_no_valid", 32'(l_pulses - lp0 + r_pulses - rp0), 32'd0);
    chk("mid_l_out", 32'(l_out), 32'd0);
    chk("mid_r_out", 32'(r_out), 32'd0);
    chk("mid_overrun", 32'(overrun), 32'd0);
    chk("mid_busy_after", 32'(busy), 32'd0);
    step(1'b1, 20'h7FFFF, 20'hFA0C0, "post_rst_r");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
